// File: rtl/emif_axi_rd_limiter.sv
// AXI read-burst limiter in front of an EMIF: registers AR requests, issues them only while
// in-flight bursts are below MAX_OUTSTANDING, and passes the R channel straight through.
module emif_axi_rd_limiter #(
  parameter int unsigned ID_WIDTH        = 9,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // Upstream AR
  input  logic                                   s_arvalid,
  output logic                                   s_arready,
  input  logic [ID_WIDTH-1:0]                    s_arid,
  input  logic [ADDR_WIDTH-1:0]                  s_araddr,
  input  logic [LEN_WIDTH-1:0]                   s_arlen,
  input  logic [2:0]                             s_arsize,
  input  logic [1:0]                             s_arburst,
  input  logic [USER_WIDTH-1:0]                  s_aruser,
  // Downstream AR
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  output logic [ID_WIDTH-1:0]                    m_arid,
  output logic [ADDR_WIDTH-1:0]                  m_araddr,
  output logic [LEN_WIDTH-1:0]                   m_arlen,
  output logic [2:0]                             m_arsize,
  output logic [1:0]                             m_arburst,
  output logic [USER_WIDTH-1:0]                  m_aruser,
  // Downstream R
  input  logic                                   m_rvalid,
  output logic                                   m_rready,
  input  logic [ID_WIDTH-1:0]                    m_rid,
  input  logic [DATA_WIDTH-1:0]                  m_rdata,
  input  logic [1:0]                             m_rresp,
  input  logic                                   m_rlast,
  input  logic [USER_WIDTH-1:0]                  m_ruser,
  // Upstream R
  output logic                                   s_rvalid,
  input  logic                                   s_rready,
  output logic [ID_WIDTH-1:0]                    s_rid,
  output logic [DATA_WIDTH-1:0]                  s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rlast,
  output logic [USER_WIDTH-1:0]                  s_ruser,
  // Status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_underflow
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  logic                  ar_full_q, ar_full_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [USER_WIDTH-1:0] aruser_q, aruser_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic ar_up_hs, ar_dn_hs, r_last_hs;

  // Both ready/valid outputs are forced low during reset so the EMIF sees nothing stale.
  assign m_arvalid = !rst && ar_full_q && (cnt_q < MaxCnt);
  assign s_arready = !rst && (!ar_full_q || (m_arvalid && m_arready));
  assign ar_dn_hs  = m_arvalid && m_arready;
  assign ar_up_hs  = s_arvalid && s_arready;
  assign r_last_hs = m_rvalid && s_rready && m_rlast;

  assign m_arid    = arid_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = arburst_q;
  assign m_aruser  = aruser_q;

  assign s_rvalid = m_rvalid;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign s_ruser  = m_ruser;
  assign m_rready = s_rready;

  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

  always_comb begin
    ar_full_d = ar_full_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    aruser_d  = aruser_q;
    if (ar_up_hs) begin
      ar_full_d = 1'b1;
      arid_d    = s_arid;
      araddr_d  = s_araddr;
      arlen_d   = s_arlen;
      arsize_d  = s_arsize;
      arburst_d = s_arburst;
      aruser_d  = s_aruser;
    end else if (ar_dn_hs) begin
      ar_full_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({ar_dn_hs, r_last_hs})
      2'b10: cnt_d = cnt_q + 1'b1;
      2'b01: begin
        // A burst completing with nothing in flight is a protocol error; hold at zero.
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_full_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      ar_full_q <= ar_full_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload needs no reset: it is only observed while ar_full_q is set.
  always_ff @(posedge clk) begin
    arid_q    <= arid_d;
    araddr_q  <= araddr_d;
    arlen_q   <= arlen_d;
    arsize_q  <= arsize_d;
    arburst_q <= arburst_d;
    aruser_q  <= aruser_d;
  end

endmodule

// File: tb/tb_emif_axi_rd_limiter.sv
// Directed bench for emif_axi_rd_limiter with MAX_OUTSTANDING=4: inputs change 1 ns after
// each rising edge, outputs are checked mid-cycle.
module tb_emif_axi_rd_limiter;

  localparam int unsigned IdW   = 9;
  localparam int unsigned AddrW = 32;
  localparam int unsigned LenW  = 8;
  localparam int unsigned DataW = 512;
  localparam int unsigned UserW = 1;
  localparam int unsigned Max   = 4;
  localparam int unsigned CntW  = $clog2(Max + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             s_arvalid, s_arready;
  logic [IdW-1:0]   s_arid;
  logic [AddrW-1:0] s_araddr;
  logic [LenW-1:0]  s_arlen;
  logic [2:0]       s_arsize;
  logic [1:0]       s_arburst;
  logic [UserW-1:0] s_aruser;
  logic             m_arvalid, m_arready;
  logic [IdW-1:0]   m_arid;
  logic [AddrW-1:0] m_araddr;
  logic [LenW-1:0]  m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic [UserW-1:0] m_aruser;
  logic             m_rvalid, m_rready;
  logic [IdW-1:0]   m_rid;
  logic [DataW-1:0] m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic [UserW-1:0] m_ruser;
  logic             s_rvalid, s_rready;
  logic [IdW-1:0]   s_rid;
  logic [DataW-1:0] s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic [UserW-1:0] s_ruser;
  logic [CntW-1:0]  outstanding;
  logic             err_underflow;

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  int dn    = 0;

  always #5 clk = ~clk;

  emif_axi_rd_limiter #(
    .ID_WIDTH       (IdW),
    .ADDR_WIDTH     (AddrW),
    .LEN_WIDTH      (LenW),
    .DATA_WIDTH     (DataW),
    .USER_WIDTH     (UserW),
    .MAX_OUTSTANDING(Max)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_arid       (s_arid),
    .s_araddr     (s_araddr),
    .s_arlen      (s_arlen),
    .s_arsize     (s_arsize),
    .s_arburst    (s_arburst),
    .s_aruser     (s_aruser),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_arid       (m_arid),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arsize     (m_arsize),
    .m_arburst    (m_arburst),
    .m_aruser     (m_aruser),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .m_rid        (m_rid),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_rlast      (m_rlast),
    .m_ruser      (m_ruser),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .s_rid        (s_rid),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rlast      (s_rlast),
    .s_ruser      (s_ruser),
    .outstanding  (outstanding),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = 3'd6; s_arburst = 2'b01; s_aruser = '0;
    m_arready = 1'b0;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0;
    s_rready = 1'b0;

    // Reset state
    tick(); tick(); #4;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    tick(); rst = 1'b0; #4;
    chk("post_rst_s_arready", 64'(s_arready), 64'd1);

    // Single burst: id 5, len 3
    tick();
    m_arready = 1'b1; s_arvalid = 1'b1; s_arid = 9'd5; s_arlen = 8'd3; s_araddr = 32'h1000;
    s_aruser = 1'b1;
    #4;
    chk("single_s_arready", 64'(s_arready), 64'd1);
    chk("single_m_arvalid_early", 64'(m_arvalid), 64'd0);
    tick(); s_arvalid = 1'b0; #4;
    chk("single_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("single_m_arid", 64'(m_arid), 64'd5);
    chk("single_m_arlen", 64'(m_arlen), 64'd3);
    chk("single_m_araddr", 64'(m_araddr), 64'h1000);
    chk("single_m_arburst", 64'(m_arburst), 64'd1);
    chk("single_m_aruser", 64'(m_aruser), 64'd1);
    chk("single_out0", 64'(outstanding), 64'd0);
    tick(); #4;
    chk("single_out1", 64'(outstanding), 64'd1);
    chk("single_m_arvalid_done", 64'(m_arvalid), 64'd0);
    for (int beat = 0; beat < 4; beat++) begin
      tick();
      m_rvalid = 1'b1; s_rready = 1'b1; m_rid = 9'd5;
      m_rdata = {8{64'hA0 + 64'(beat)}};
      m_rresp = (beat == 1) ? 2'b10 : 2'b00;
      m_rlast = (beat == 3);
      m_ruser = 1'(beat);
      #4;
      chk("r_s_rvalid", 64'(s_rvalid), 64'd1);
      chk("r_s_rdata_lo", s_rdata[63:0], 64'hA0 + 64'(beat));
      chk("r_s_rdata_hi", s_rdata[511:448], 64'hA0 + 64'(beat));
      chk("r_s_rid", 64'(s_rid), 64'd5);
      chk("r_s_rresp", 64'(s_rresp), (beat == 1) ? 64'd2 : 64'd0);
      chk("r_s_rlast", 64'(s_rlast), (beat == 3) ? 64'd1 : 64'd0);
      chk("r_s_ruser", 64'(s_ruser), 64'(beat % 2));
      chk("r_m_rready", 64'(m_rready), 64'd1);
      chk("r_out_during", 64'(outstanding), 64'd1);
    end
    tick(); m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b0; #4;
    chk("single_out_end", 64'(outstanding), 64'd0);
    chk("r_m_rready_low", 64'(m_rready), 64'd0);
    chk("single_err", 64'(err_underflow), 64'd0);

    // Credit exhaustion: six requests offered, no R traffic
    for (int c = 0; c < 10; c++) begin
      tick();
      s_arvalid = (acc < 6);
      s_arid = 9'(acc);
      s_araddr = 32'h100 * 32'(acc);
      #4;
      if (s_arvalid && s_arready) acc++;
      if (m_arvalid && m_arready) dn++;
    end
    chk("credit_dn_count", 64'(dn), 64'd4);
    chk("credit_up_count", 64'(acc), 64'd5);
    chk("credit_out", 64'(outstanding), 64'd4);
    chk("credit_s_arready", 64'(s_arready), 64'd0);
    chk("credit_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("credit_held_id", 64'(m_arid), 64'd4);
    tick(); m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1; #4;
    chk("credit_rlast_out", 64'(outstanding), 64'd4);
    tick(); m_rvalid = 1'b0; m_rlast = 1'b0; #4;
    chk("credit_5th_valid", 64'(m_arvalid), 64'd1);
    chk("credit_5th_id", 64'(m_arid), 64'd4);
    chk("credit_5th_s_arready", 64'(s_arready), 64'd1);
    chk("credit_out3", 64'(outstanding), 64'd3);
    tick(); s_arvalid = 1'b0; #4;
    chk("credit_out4_again", 64'(outstanding), 64'd4);
    chk("credit_6th_id", 64'(m_arid), 64'd5);
    chk("credit_6th_blocked", 64'(m_arvalid), 64'd0);

    // Drain to 2 with the held request blocked, then simultaneous AR + rlast
    tick(); m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; #4;
    tick(); #4;
    chk("drain_out3", 64'(outstanding), 64'd3);
    chk("drain_valid", 64'(m_arvalid), 64'd1);
    tick(); m_arready = 1'b1; #4;
    chk("simul_out_before", 64'(outstanding), 64'd2);
    chk("simul_valid", 64'(m_arvalid), 64'd1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    // Backpressure: request id 9 held with m_arready low for five cycles
    m_arready = 1'b0; s_arvalid = 1'b1; s_arid = 9'd9; s_araddr = 32'h2000; s_arlen = 8'd7;
    #4;
    chk("simul_out_after", 64'(outstanding), 64'd2);
    chk("bp_accept", 64'(s_arready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick(); s_arid = 9'd10; s_araddr = 32'h3000; s_arlen = 8'd1; #4;
      chk("bp_valid", 64'(m_arvalid), 64'd1);
      chk("bp_id", 64'(m_arid), 64'd9);
      chk("bp_addr", 64'(m_araddr), 64'h2000);
      chk("bp_len", 64'(m_arlen), 64'd7);
      chk("bp_s_arready", 64'(s_arready), 64'd0);
    end
    tick(); m_arready = 1'b1; #4;
    chk("bp_release_id", 64'(m_arid), 64'd9);
    chk("bp_release_s_arready", 64'(s_arready), 64'd1);
    tick(); s_arvalid = 1'b0; #4;
    chk("bp_next_out", 64'(outstanding), 64'd3);
    chk("bp_next_id", 64'(m_arid), 64'd10);
    chk("bp_next_addr", 64'(m_araddr), 64'h3000);
    chk("bp_next_valid", 64'(m_arvalid), 64'd1);
    tick(); #4;
    chk("bp_no_dup_out", 64'(outstanding), 64'd4);
    chk("bp_no_dup_valid", 64'(m_arvalid), 64'd0);

    // Reset mid-burst at outstanding=3 with a held request
    tick();
    m_arready = 1'b0; s_arvalid = 1'b1; s_arid = 9'd11;
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    #4;
    chk("mid_load_ready", 64'(s_arready), 64'd1);
    tick(); s_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; #4;
    chk("mid_out3", 64'(outstanding), 64'd3);
    chk("mid_full_valid", 64'(m_arvalid), 64'd1);
    tick(); rst = 1'b1; #4;
    chk("mid_rst_valid", 64'(m_arvalid), 64'd0);
    chk("mid_rst_s_arready", 64'(s_arready), 64'd0);
    tick(); #4;
    chk("mid_rst_out", 64'(outstanding), 64'd0);
    tick(); rst = 1'b0; #4;
    chk("mid_rel_s_arready", 64'(s_arready), 64'd1);
    chk("mid_rel_valid", 64'(m_arvalid), 64'd0);
    chk("mid_rel_out", 64'(outstanding), 64'd0);

    // Underflow: rlast with nothing in flight
    tick(); m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1; #4;
    chk("uf_before", 64'(err_underflow), 64'd0);
    tick(); m_rvalid = 1'b0; m_rlast = 1'b0; #4;
    chk("uf_set", 64'(err_underflow), 64'd1);
    chk("uf_out", 64'(outstanding), 64'd0);
    tick(); m_rvalid = 1'b1; #4;
    tick(); m_rvalid = 1'b0; #4;
    chk("uf_nonlast_out", 64'(outstanding), 64'd0);
    tick(); tick(); tick(); #4;
    chk("uf_sticky", 64'(err_underflow), 64'd1);
    tick(); rst = 1'b1; #4;
    tick(); rst = 1'b0; #4;
    chk("uf_cleared", 64'(err_underflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
